// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int         INDEX_BITS_DEF = 7;
    localparam logic [2:0] MC_LEN_WORD    = 3'd4;
    localparam logic [1:0] PORT_ID_DEF    = 2'd0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        DRAIN     = 2'd3
    } state_e;

    function automatic int tag_bits(input int index_bits);
        return 30 - index_bits;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag+data RAM: one synchronous read port, one write port, no reset.
module icache_array #(
    parameter int AW = 7,
    parameter int DW = 55
) (
    input  logic          clk_in,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and mc port 0.
module icache
    import icache_pkg::*;
#(
    parameter int         INDEX_BITS = INDEX_BITS_DEF,
    parameter int         TAG_BITS   = tag_bits(INDEX_BITS_DEF),
    parameter logic [1:0] PORT_ID    = PORT_ID_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_re,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    input  logic        flush,
    output logic [31:0] if_inst,
    output logic        if_done,
    output logic        if_busy,
    output logic        mc_re,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len_in_byte,
    output logic [1:0]  mc_port_id,
    input  logic [31:0] mc_r_data,
    input  logic        mc_busy,
    input  logic        mc_done
);

    localparam int DEPTH = 2**INDEX_BITS;
    localparam int DW    = TAG_BITS + 32;

    state_e            state_q, state_d;
    logic [31:2]       req_addr_q, req_addr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              if_done_q, if_done_d;
    logic              mc_re_q, mc_re_d;
    logic [31:0]       mc_addr_q, mc_addr_d;
    logic              stale_q, stale_d;

    logic                  arr_re, arr_we, fill_set, hit;
    logic [DW-1:0]         arr_rdata;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  unused_ok;

    assign req_idx   = req_addr_q[INDEX_BITS+1:2];
    assign req_tag   = req_addr_q[31:INDEX_BITS+2];
    // A flush seen during LOOKUP must not return the line it is invalidating.
    assign hit       = valid_q[req_idx] && (arr_rdata[DW-1:32] == req_tag) && !flush;
    assign unused_ok = ^{mc_busy, if_addr[1:0]};

    icache_array #(.AW(INDEX_BITS), .DW(DW)) u_array (
        .clk_in (clk_in),
        .re     (arr_re),
        .raddr  (if_addr[INDEX_BITS+1:2]),
        .rdata  (arr_rdata),
        .we     (arr_we),
        .waddr  (req_idx),
        .wdata  ({req_tag, mc_r_data})
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        if_inst_d  = if_inst_q;
        if_done_d  = 1'b0;
        mc_re_d    = mc_re_q;
        mc_addr_d  = mc_addr_q;
        stale_d    = stale_q;
        arr_re     = 1'b0;
        arr_we     = 1'b0;
        fill_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_re) begin
                    req_addr_d = if_addr[31:2];
                    arr_re     = rdy_in;
                    stale_d    = 1'b0;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (if_abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    if_inst_d = arr_rdata[31:0];
                    if_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mc_re_d   = 1'b1;
                    mc_addr_d = {req_addr_q, 2'b00};
                    state_d   = MISS_WAIT;
                end
            end
            MISS_WAIT, DRAIN: begin
                if (flush) stale_d = 1'b1;
                if (mc_done) begin
                    // The mc transaction always completes and fills; only the pulse is optional.
                    arr_we   = rdy_in;
                    fill_set = !stale_q;
                    mc_re_d  = 1'b0;
                    state_d  = IDLE;
                    if (state_q == MISS_WAIT && !if_abort) begin
                        if_inst_d = mc_r_data;
                        if_done_d = 1'b1;
                    end
                end else if (state_q == MISS_WAIT && if_abort) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (fill_set) valid_d[req_idx] = 1'b1;
        if (flush)    valid_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            valid_q    <= '0;
            if_inst_q  <= '0;
            if_done_q  <= 1'b0;
            mc_re_q    <= 1'b0;
            mc_addr_q  <= '0;
            stale_q    <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
            if_inst_q  <= if_inst_d;
            if_done_q  <= if_done_d;
            mc_re_q    <= mc_re_d;
            mc_addr_q  <= mc_addr_d;
            stale_q    <= stale_d;
        end
    end

    assign if_inst        = if_inst_q;
    assign if_done        = if_done_q;
    assign if_busy        = (state_q != IDLE);
    assign mc_re          = mc_re_q;
    assign mc_addr        = mc_addr_q;
    assign mc_len_in_byte = MC_LEN_WORD;
    assign mc_port_id     = PORT_ID;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: miss/hit, conflict, abort, flush race, pause, reset.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_re, if_abort, flush, mc_busy, mc_done;
    logic [31:0] if_addr, mc_r_data;
    logic [31:0] if_inst, mc_addr;
    logic        if_done, if_busy, mc_re;
    logic [2:0]  mc_len_in_byte;
    logic [1:0]  mc_port_id;

    int checks   = 0;
    int failures = 0;

    icache dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_re(if_re), .if_addr(if_addr), .if_abort(if_abort), .flush(flush),
        .if_inst(if_inst), .if_done(if_done), .if_busy(if_busy),
        .mc_re(mc_re), .mc_addr(mc_addr), .mc_len_in_byte(mc_len_in_byte),
        .mc_port_id(mc_port_id), .mc_r_data(mc_r_data), .mc_busy(mc_busy),
        .mc_done(mc_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Presents a fetch for one accepting edge; DUT is then in LOOKUP.
    task automatic fetch(input logic [31:0] a);
        if_re   = 1'b1;
        if_addr = a;
        step();
        if_re   = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d);
        mc_done   = 1'b1;
        mc_busy   = 1'b1;
        mc_r_data = d;
        step();
        mc_done   = 1'b0;
        mc_busy   = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; if_re = 0; if_abort = 0; flush = 0;
        mc_busy = 0; mc_done = 0; if_addr = '0; mc_r_data = '0;
        #12;
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
        checks++; if (if_busy !== 1'b0) begin failures++; $display("FAIL reset_if_busy got=%b exp=0", if_busy); end
        checks++; if (mc_re !== 1'b0) begin failures++; $display("FAIL reset_mc_re got=%b exp=0", mc_re); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
        checks++; if (mc_addr !== 32'h0) begin failures++; $display("FAIL reset_mc_addr got=%h exp=0", mc_addr); end
        step();
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        fetch(32'h0);
        checks++; if (if_busy !== 1'b1) begin failures++; $display("FAIL cold_busy got=%b exp=1", if_busy); end
        step();
        checks++; if (mc_re !== 1'b1) begin failures++; $display("FAIL cold_mc_re got=%b exp=1", mc_re); end
        checks++; if (mc_addr !== 32'h0) begin failures++; $display("FAIL cold_mc_addr got=%h exp=0", mc_addr); end
        checks++; if (mc_len_in_byte !== 3'd4) begin failures++; $display("FAIL cold_len got=%0d exp=4", mc_len_in_byte); end
        checks++; if (mc_port_id !== 2'd0) begin failures++; $display("FAIL cold_port got=%0d exp=0", mc_port_id); end
        step(); step();
        checks++; if (mc_re !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL cold_hold mc_re=%b if_done=%b exp 1/0", mc_re, if_done); end
        serve(32'h00000013);
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL cold_done got=%b exp=1", if_done); end
        checks++; if (if_inst !== 32'h13) begin failures++; $display("FAIL cold_inst got=%h exp=00000013", if_inst); end
        checks++; if (mc_re !== 1'b0) begin failures++; $display("FAIL cold_mc_re_drop got=%b exp=0", mc_re); end
        step();
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL cold_done_pulse got=%b exp=0", if_done); end
    endtask

    task automatic test_hit();
        fetch(32'h0);
        checks++; if (if_done !== 1'b0 || mc_re !== 1'b0) begin failures++; $display("FAIL hit_edge1 if_done=%b mc_re=%b exp 0/0", if_done, mc_re); end
        step();
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL hit_done got=%b exp=1", if_done); end
        checks++; if (if_inst !== 32'h13) begin failures++; $display("FAIL hit_inst got=%h exp=00000013", if_inst); end
        checks++; if (mc_re !== 1'b0) begin failures++; $display("FAIL hit_mc_re got=%b exp=0", mc_re); end
        step();
    endtask

    task automatic test_conflict();
        fetch(32'h200); step();
        checks++; if (mc_re !== 1'b1 || mc_addr !== 32'h200) begin failures++; $display("FAIL conf_miss200 mc_re=%b addr=%h exp 1/00000200", mc_re, mc_addr); end
        serve(32'h00100093);
        checks++; if (if_done !== 1'b1 || if_inst !== 32'h00100093) begin failures++; $display("FAIL conf_fill200 done=%b inst=%h exp 1/00100093", if_done, if_inst); end
        step();
        fetch(32'h0); step();
        checks++; if (mc_re !== 1'b1 || mc_addr !== 32'h0) begin failures++; $display("FAIL conf_miss0 mc_re=%b addr=%h exp 1/0", mc_re, mc_addr); end
        serve(32'h00000013);
        checks++; if (if_inst !== 32'h13) begin failures++; $display("FAIL conf_fill0 got=%h exp=00000013", if_inst); end
        step();
        fetch(32'h200); step();
        checks++; if (mc_re !== 1'b1) begin failures++; $display("FAIL conf_remiss200 got=%b exp=1", mc_re); end
        serve(32'h00100093);
        step();
    endtask

    task automatic test_abort();
        fetch(32'h4); step();
        checks++; if (mc_re !== 1'b1 || mc_addr !== 32'h4) begin failures++; $display("FAIL abort_miss mc_re=%b addr=%h exp 1/00000004", mc_re, mc_addr); end
        if_abort = 1'b1; step(); if_abort = 1'b0;
        checks++; if (mc_re !== 1'b1 || if_busy !== 1'b1) begin failures++; $display("FAIL abort_drain mc_re=%b busy=%b exp 1/1", mc_re, if_busy); end
        step();
        serve(32'h00200113);
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", if_done); end
        checks++; if (mc_re !== 1'b0 || if_busy !== 1'b0) begin failures++; $display("FAIL abort_idle mc_re=%b busy=%b exp 0/0", mc_re, if_busy); end
        checks++; if (if_inst !== 32'h00100093) begin failures++; $display("FAIL abort_inst_hold got=%h exp=00100093", if_inst); end
        step();
        fetch(32'h4); step();
        checks++; if (if_done !== 1'b1 || if_inst !== 32'h00200113 || mc_re !== 1'b0) begin failures++; $display("FAIL abort_rehit done=%b inst=%h mc_re=%b exp 1/00200113/0", if_done, if_inst, mc_re); end
        step();
    endtask

    task automatic test_flush_race();
        fetch(32'h8); step();
        checks++; if (mc_re !== 1'b1) begin failures++; $display("FAIL flush_miss got=%b exp=1", mc_re); end
        flush = 1'b1;
        serve(32'h00300193);
        flush = 1'b0;
        checks++; if (if_done !== 1'b1 || if_inst !== 32'h00300193) begin failures++; $display("FAIL flush_done done=%b inst=%h exp 1/00300193", if_done, if_inst); end
        checks++; if (dut.valid_q[2] !== 1'b0) begin failures++; $display("FAIL flush_valid2 got=%b exp=0", dut.valid_q[2]); end
        step();
        fetch(32'h8); step();
        checks++; if (mc_re !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL flush_remiss mc_re=%b done=%b exp 1/0", mc_re, if_done); end
        serve(32'h00300193);
        step();
        fetch(32'h4); step();
        checks++; if (mc_re !== 1'b1) begin failures++; $display("FAIL flush_all_lines mc_re=%b exp=1", mc_re); end
        serve(32'h00200113);
        step();
    endtask

    task automatic test_pause_reset();
        fetch(32'hC); step();
        checks++; if (mc_re !== 1'b1 || mc_addr !== 32'hC) begin failures++; $display("FAIL pause_miss mc_re=%b addr=%h exp 1/0000000c", mc_re, mc_addr); end
        rdy_in = 1'b0; mc_done = 1'b1; mc_r_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mc_re !== 1'b1 || if_done !== 1'b0 || if_busy !== 1'b1) begin failures++; $display("FAIL pause_frozen%0d mc_re=%b done=%b busy=%b exp 1/0/1", i, mc_re, if_done, if_busy); end
        end
        rdy_in = 1'b1; mc_done = 1'b0;
        step();
        checks++; if (mc_re !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL pause_after mc_re=%b done=%b exp 1/0", mc_re, if_done); end
        rst_in = 1'b0;
        #2;
        checks++; if (mc_re !== 1'b0 || if_busy !== 1'b0 || if_done !== 1'b0) begin failures++; $display("FAIL async_reset mc_re=%b busy=%b done=%b exp 0/0/0", mc_re, if_busy, if_done); end
        step();
        rst_in = 1'b1;
        step();
        fetch(32'h0); step();
        checks++; if (mc_re !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL reset_cold mc_re=%b done=%b exp 1/0", mc_re, if_done); end
        serve(32'h00000013);
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_abort();
        test_flush_race();
        test_pause_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
